stdcell_gate_tester: RTL and testbench

- Sequential stimulus/response engine: the driving and checking end for a single 4-input complex gate from the standard-cell library (AOI22, OAI22, AOI21, OAI21).
- Sweeps all 16 input vectors onto the gate's A/B/C/D pins and holds each one for a settle window.
- Samples the gate's Y against a built-in golden model, counts mismatches and records the first failing vector.
- Sits beside a DUT cell instance in silicon-bring-up and characterization test structures; controlled by a START/DONE handshake.

---
 rtl/stdcell_gate_tester.sv | 95 +++++++++
 tb/tb_stdcell_gate_tester.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stdcell_gate_tester.sv
// stdcell_gate_tester: sweeps all 16 vectors into a 4-input complex gate and checks Y against a golden model
module stdcell_gate_tester #(
  parameter int SETTLE_CYC = 2,
  parameter int PASSES     = 1,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [1:0]       FUNC_SEL,
  input  logic             Y_I,
  output logic             A_O,
  output logic             B_O,
  output logic             C_O,
  output logic             D_O,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL_SEEN,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FIRST_FAIL
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);
  state_t     r_state;
  logic [3:0] r_vec;
  logic [7:0] r_settle;
  logic [7:0] r_pass;
  logic [1:0] r_fsel;
  logic       w_a, w_b, w_c, w_d, w_gold, w_mis;
  assign {w_a, w_b, w_c, w_d} = r_vec;
  assign {A_O, B_O, C_O, D_O} = r_vec;
  assign w_gold = r_fsel == 2'd0 ? ~((w_a & w_b) | (w_c & w_d)) :
                  r_fsel == 2'd1 ? ~((w_a | w_b) & (w_c | w_d)) :
                  r_fsel == 2'd2 ? ~((w_a & w_b) | w_c) :
                                   ~((w_a | w_b) & w_c);
  assign w_mis = Y_I != w_gold;
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_settle   <= '0;
      r_pass     <= '0;
      r_fsel     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      FAIL_SEEN  <= 1'b0;
      ERR_CNT    <= '0;
      FIRST_FAIL <= '0;
    end else begin
      case (r_state)
        IDLE: if (START) begin
          r_fsel     <= FUNC_SEL;
          r_vec      <= '0;
          r_pass     <= '0;
          r_settle   <= '0;
          ERR_CNT    <= '0;
          FAIL_SEEN  <= 1'b0;
          FIRST_FAIL <= '0;
          DONE       <= 1'b0;
          PASS       <= 1'b0;
          BUSY       <= 1'b1;
          r_state    <= SETTLE;
        end
        SETTLE: begin
          r_settle <= r_settle + 8'd1;
          if (r_settle == SETTLE_LAST) r_state <= SAMPLE;
        end
        SAMPLE: begin
          if (w_mis) begin
            if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_W'(1);
            if (!FAIL_SEEN) begin
              FIRST_FAIL <= r_vec;
              FAIL_SEEN  <= 1'b1;
            end
          end
          if (r_vec == 4'hf && r_pass == PASS_LAST) begin
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            PASS    <= !(FAIL_SEEN || w_mis);
            r_state <= IDLE;
          end else begin
            r_vec    <= r_vec + 4'd1;
            r_pass   <= r_vec == 4'hf ? r_pass + 8'd1 : r_pass;
            r_settle <= '0;
            r_state  <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stdcell_gate_tester.sv
// tb_stdcell_gate_tester: directed runs with a scoreboard of expected run results
module tb_stdcell_gate_tester;
  logic clk = 0, r = 0, start = 0;
  logic [1:0] fsel = 0;
  int ymode = 0;
  logic y0, y1;
  logic a0, b0, c0, d0, busy0, done0, pass0, fs0;
  logic [7:0] err0;
  logic [3:0] ff0;
  logic a1, b1, c1, d1, busy1, done1, pass1, fs1;
  logic [2:0] err1;
  logic [3:0] ff1;
  int total = 0, bad = 0;
  typedef struct {int err; int first; int pass;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  assign y0 = ymode == 0 ? ~((a0 & b0) | (c0 & d0)) : ymode == 2;
  assign y1 = 1'b0;

  stdcell_gate_tester u0 (
    .CLK(clk), .R(r), .START(start), .FUNC_SEL(fsel), .Y_I(y0),
    .A_O(a0), .B_O(b0), .C_O(c0), .D_O(d0), .BUSY(busy0), .DONE(done0),
    .PASS(pass0), .FAIL_SEEN(fs0), .ERR_CNT(err0), .FIRST_FAIL(ff0));

  stdcell_gate_tester #(.SETTLE_CYC(2), .PASSES(2), .ERR_W(3)) u1 (
    .CLK(clk), .R(r), .START(start), .FUNC_SEL(fsel), .Y_I(y1),
    .A_O(a1), .B_O(b1), .C_O(c1), .D_O(d1), .BUSY(busy1), .DONE(done1),
    .PASS(pass1), .FAIL_SEEN(fs1), .ERR_CNT(err1), .FIRST_FAIL(ff1));

  function automatic exp_t model(int fs, int ym, int passes, int errw);
    exp_t e;
    logic a, b, c, d, g, y;
    logic [3:0] v;
    int mis = 0;
    e.err = 0;
    e.first = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 16; i++) begin
        v = 4'(i);
        {a, b, c, d} = v;
        g = fs == 0 ? ~((a & b) | (c & d)) : fs == 1 ? ~((a | b) & (c | d)) :
            fs == 2 ? ~((a & b) | c) : ~((a | b) & c);
        y = ym == 0 ? ~((a & b) | (c & d)) : ym == 2;
        if (y != g) begin
          if (mis == 0) e.first = i;
          mis++;
          if (e.err < (1 << errw) - 1) e.err++;
        end
      end
    e.pass = mis == 0;
    return e;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(logic [1:0] f, int ym);
    @(negedge clk);
    fsel = f;
    ymode = ym;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done0(int repulse, output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (repulse != 0 && (n == 10 || n == 20)) begin
        start = 1;
        fsel = ~fsel;
      end
      if (repulse != 0 && (n == 11 || n == 21)) start = 0;
      if (done0) break;
    end
  endtask

  task automatic run0(logic [1:0] f, int ym, int repulse, string tag);
    exp_t e;
    int n;
    pulse_start(f, ym);
    q.push_back(model(f, ym, 1, 8));
    chk({tag, "_busy"}, busy0, 1);
    wait_done0(repulse, n);
    e = q.pop_front();
    chk({tag, "_cycles"}, n, 48);
    chk({tag, "_err"}, err0, e.err);
    chk({tag, "_first"}, ff0, e.first);
    chk({tag, "_pass"}, pass0, e.pass);
    chk({tag, "_failseen"}, fs0, !e.pass);
    chk({tag, "_busyend"}, busy0, 0);
    chk({tag, "_vec"}, {a0, b0, c0, d0}, 15);
  endtask

  initial begin
    exp_t e;
    int n;
    #12;
    chk("rst_outs", {a0, b0, c0, d0, busy0, done0, pass0, fs0, err0, ff0}, 0);
    @(negedge clk) r = 1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy0, 0);
    run0(2'd0, 0, 0, "good_aoi22");
    chk("good_err_const", err0, 0);
    run0(2'd0, 1, 0, "stuck0");
    chk("stuck0_const", err0, 9);
    run0(2'd0, 2, 0, "stuck1");
    chk("stuck1_first_const", ff0, 4'b0011);
    run0(2'd1, 0, 0, "oai22_vs_aoi");
    chk("oai_const", err0, 6);
    run0(2'd2, 0, 0, "aoi21");
    run0(2'd3, 2, 0, "oai21");
    run0(2'd0, 1, 1, "ignored_start");
    // back-to-back: START held across DONE restarts on the next edge
    @(negedge clk);
    fsel = 0;
    ymode = 0;
    start = 1;
    @(posedge clk);
    #1;
    wait_done0(0, n);
    chk("b2b_cycles", n, 48);
    @(posedge clk);
    #1;
    chk("b2b_done_clr", done0, 0);
    chk("b2b_busy", busy0, 1);
    start = 0;
    wait_done0(0, n);
    chk("b2b_pass", pass0, 1);
    // async reset in the settle window of vector 5
    run0(2'd0, 1, 0, "pre_reset");
    pulse_start(2'd0, 1);
    repeat (16) @(posedge clk);
    #1;
    chk("mid_vec", {a0, b0, c0, d0}, 5);
    r = 0;
    #1;
    chk("async_rst", {a0, b0, c0, d0, busy0, done0, pass0, fs0, err0, ff0}, 0);
    @(negedge clk) r = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {busy0, done0, a0, b0, c0, d0}, 0);
    run0(2'd0, 0, 0, "post_rst");
    // saturating counter over two passes
    @(negedge clk) r = 0;
    @(negedge clk) r = 1;
    pulse_start(2'd0, 0);
    e = model(0, 1, 2, 3);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (done1) break;
    end
    chk("sat_cycles", n, 96);
    chk("sat_err", err1, e.err);
    chk("sat_err_const", err1, 7);
    chk("sat_first", ff1, e.first);
    chk("sat_pass", pass1, 0);
    chk("sat_failseen", fs1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
